bcd_cascade_counter: RTL

- Parametrised multi-digit BCD (decade) counter; successor to the single-digit 4-bit decade counter.
- Adds digit count, up/down direction, count enable, synchronous parallel load with BCD sanitising, and a wrap-or-saturate mode.
- Provides a terminal-count flag and a wrap pulse for cascading or event timing.
- Used as a display/event counter feeding 7-segment drivers and timers.

---
 rtl/bcd_cascade_counter.sv | 109 ++++++++++
 1 files changed

// File: rtl/bcd_cascade_counter.sv
// Multi-digit packed-BCD up/down counter with parallel load, wrap/saturate limits,
// terminal-count flag for cascading, and registered wrap / bad-load pulses.
module bcd_cascade_counter #(
  parameter int unsigned DIGITS = 2,
  parameter bit          SAT    = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  wrap,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0]      r_count;
  logic              r_wrap;
  logic              r_load_err;

  logic [DIGITS:0]   w_up_chain;
  logic [DIGITS:0]   w_dn_chain;
  logic [W-1:0]      w_up_val;
  logic [W-1:0]      w_dn_val;
  logic [W-1:0]      w_load_val;
  logic [DIGITS-1:0] w_bad_digit;
  logic              w_at_max;
  logic              w_at_min;
  logic [W-1:0]      w_count_nxt;
  logic              w_wrap_nxt;
  logic              w_load_err_nxt;

  assign w_up_chain[0] = 1'b1;
  assign w_dn_chain[0] = 1'b1;

  // Per-digit ripple enables: a digit steps when every lower digit sits at its limit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [3:0] w_dig;
    logic [3:0] w_ld;

    assign w_dig = r_count[4*g +: 4];
    assign w_ld  = load_val[4*g +: 4];

    assign w_up_chain[g+1] = w_up_chain[g] & (w_dig == 4'd9);
    assign w_dn_chain[g+1] = w_dn_chain[g] & (w_dig == 4'd0);

    assign w_up_val[4*g +: 4] = !w_up_chain[g]   ? w_dig :
                                (w_dig == 4'd9)  ? 4'd0  : w_dig + 4'd1;
    assign w_dn_val[4*g +: 4] = !w_dn_chain[g]   ? w_dig :
                                (w_dig == 4'd0)  ? 4'd9  : w_dig - 4'd1;

    assign w_bad_digit[g]       = (w_ld > 4'd9);
    assign w_load_val[4*g +: 4] = w_bad_digit[g] ? 4'd9 : w_ld;
  end

  assign w_at_max = w_up_chain[DIGITS];
  assign w_at_min = w_dn_chain[DIGITS];

  // Next-count selection: load beats enable, enable beats hold.
  always_comb begin
    w_count_nxt    = r_count;
    w_wrap_nxt     = 1'b0;
    w_load_err_nxt = 1'b0;
    if (load) begin
      w_count_nxt    = w_load_val;
      w_load_err_nxt = |w_bad_digit;
    end else if (en) begin
      if (up_dn) begin
        if (w_at_max && SAT) begin
          w_count_nxt = r_count;
        end else begin
          w_count_nxt = w_up_val;
          w_wrap_nxt  = w_at_max;
        end
      end else begin
        if (w_at_min && SAT) begin
          w_count_nxt = r_count;
        end else begin
          w_count_nxt = w_dn_val;
          w_wrap_nxt  = w_at_min;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_wrap     <= w_wrap_nxt;
      r_load_err <= w_load_err_nxt;
    end
  end

  assign count    = r_count;
  assign wrap     = r_wrap;
  assign load_err = r_load_err;

  // Terminal count ignores SAT so it can directly enable a downstream stage.
  assign tc = en & ~load & (up_dn ? w_at_max : w_at_min);

endmodule
